button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_pkg.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/button_debouncer.sv | 116 +++++++++++
 tb/tb_button_debouncer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and 50 MHz default timing for the push-button debouncer.
// Used by button_debouncer (optional long-press via BUTTON_DEBOUNCER_LONG_PRESS_EN).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } button_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT   = 50_000;
    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = 50_000_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages clear to 0 on reset.
module sync_2ff (
    input  logic clock,
    input  logic reset_s2_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounced push button with press/release pulses and held level.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to enable the long_press pulse.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_s2_n,
    input  logic button_n,
    output logic button_pressed,
    output logic button_released,
    output logic button_held,
    output logic long_press
);

    localparam int unsigned    DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          btn_sync;
    button_state_t state;
    button_state_t state_nxt;
    logic [DW-1:0] count;
    logic [DW-1:0] count_nxt;
    logic          in_wait;
    logic          fire_press;
    logic          fire_release;

    sync_2ff u_sync (
        .clock      (clock),
        .reset_s2_n (reset_s2_n),
        .d          (!button_n),
        .q          (btn_sync)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (btn_sync) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_sync)             state_nxt = IDLE;
                else if (count == DB_LAST) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (!btn_sync) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_sync)              state_nxt = PRESSED;
                else if (count == DB_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_wait      = (state == PRESS_WAIT) || (state == RELEASE_WAIT);
    assign fire_press   = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    assign fire_release = (state == RELEASE_WAIT) && (state_nxt == IDLE);

    // Every state change restarts the stability count from zero.
    always_comb begin
        count_nxt = '0;
        if (state_nxt == state && in_wait) count_nxt = count + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state           <= IDLE;
            count           <= '0;
            button_pressed  <= 1'b0;
            button_released <= 1'b0;
            button_held     <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            button_pressed  <= fire_press;
            button_released <= fire_release;
            button_held     <= (state_nxt == PRESSED)
                            || (state_nxt == RELEASE_WAIT);
        end
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned    HW        = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_run;
    logic          long_q;

    // Hold time survives release bounces; it saturates so the pulse fires once.
    assign hold_run = ((state == PRESSED) || (state == RELEASE_WAIT))
                   && (hold_cnt != HOLD_LAST);

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= hold_run && ((hold_cnt + 1'b1) == HOLD_LAST);
            if (fire_press)    hold_cnt <= '0;
            else if (hold_run) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign long_press = long_q;
`else
    logic unused_long_cfg;

    assign unused_long_cfg = ^LONG_PRESS_CYCLES;
    assign long_press      = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
// Directed sequences, a segment table and random stimulus vs. a reference model.
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 10;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clock      = 1'b0;
    logic reset_s2_n = 1'b1;
    logic button_n   = 1'b1;
    logic button_pressed;
    logic button_released;
    logic button_held;
    logic long_press;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    button_debouncer #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clock           (clock),
        .reset_s2_n      (reset_s2_n),
        .button_n        (button_n),
        .button_pressed  (button_pressed),
        .button_released (button_released),
        .button_held     (button_held),
        .long_press      (long_press)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level change is accepted once the synchronized
    // input has disagreed with the accepted level for D+1 consecutive edges.
    typedef struct {
        bit s1;
        bit s2;
        bit level;
        int run;
        int age;
        bit p;
        bit r;
        bit l;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t cur, input bit bn);
        model_t n;
        n = cur;
        n.p = 1'b0;
        n.r = 1'b0;
        n.l = 1'b0;
        if (cur.level && cur.age < L - 1) begin
            n.age = cur.age + 1;
            if (n.age == L - 1) n.l = LP;
        end
        n.run = (cur.s2 != cur.level) ? cur.run + 1 : 0;
        if (n.run == D + 1) begin
            n.level = !cur.level;
            n.run   = 0;
            if (n.level) begin
                n.p   = 1'b1;
                n.age = 0;
            end else begin
                n.r = 1'b1;
            end
        end
        n.s2 = cur.s1;
        n.s1 = !bn;
        return n;
    endfunction

    always @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) m <= '{default: 0};
        else             m <= step(m, button_n);
    end

    always @(negedge clock) begin
        check("model_pressed",  button_pressed,  m.p);
        check("model_released", button_released, m.r);
        check("model_held",     button_held,     m.level);
        check("model_long",     long_press,      m.l);
    end

    typedef struct {
        bit bn;
        int cycles;
        int np;
        int nr;
        bit held;
        int nl;
    } seg_t;

    seg_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got 0 expected 1 finish");
        $fatal(1, "timeout");
    end

    initial begin
        int np;
        int nr;
        int nl;
        int run_left;
        bit lvl;

        tbl[0] = '{1'b1, 10, 0, 0, 1'b0, 0};
        tbl[1] = '{1'b0,  2, 0, 0, 1'b0, 0};
        tbl[2] = '{1'b1, 10, 0, 0, 1'b0, 0};
        tbl[3] = '{1'b0,  4, 0, 0, 1'b0, 0};
        tbl[4] = '{1'b1, 10, 0, 0, 1'b0, 0};
        tbl[5] = '{1'b0,  5, 0, 0, 1'b0, 0};
        tbl[6] = '{1'b1, 20, 1, 1, 1'b0, 0};
        tbl[7] = '{1'b0, 12, 1, 0, 1'b1, 0};
        tbl[8] = '{1'b1,  3, 0, 0, 1'b1, 0};

        // Asynchronous reset, no clock edge yet
        #1 reset_s2_n = 1'b0;
        #2;
        check("rst_pressed",  button_pressed,  0);
        check("rst_released", button_released, 0);
        check("rst_held",     button_held,     0);
        check("rst_long",     long_press,      0);
        repeat (3) @(negedge clock);
        reset_s2_n = 1'b1;
        repeat (5) @(negedge clock);

        // Clean press held 30 cycles
        button_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            check("press_pulse", button_pressed, (i == 6));
            check("press_held",  button_held,    (i >= 6));
            check("press_long",  long_press,     LP && (i == 15));
        end

        // One-cycle release glitch while pressed
        button_n = 1'b1;
        @(negedge clock);
        button_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("glitch_released", button_released, 0);
            check("glitch_held",     button_held,     1);
        end

        // Clean release
        button_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("release_pulse", button_released, (i == 6));
            check("release_held",  button_held,     (i < 6));
            check("release_press", button_pressed,  0);
        end

        // Press bounce: low 2, high 1, then low
        for (int i = 0; i < 18; i++) begin
            button_n = (i == 2);
            @(negedge clock);
            check("bounce_pulse", button_pressed, (i == 9));
            check("bounce_held",  button_held,    (i >= 9));
        end
        button_n = 1'b1;
        repeat (12) @(negedge clock);

        // Reset while in PRESS_WAIT, button kept down
        button_n = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_s2_n = 1'b0;
        #1;
        check("rstpw_pressed", button_pressed, 0);
        check("rstpw_held",    button_held,    0);
        @(negedge clock);
        reset_s2_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("rstpw_repress",  button_pressed,  (i == 6));
            check("rstpw_released", button_released, 0);
        end

        // Reset while PRESSED, button released during reset
        check("rstp_pre_held", button_held, 1);
        #2 reset_s2_n = 1'b0;
        #1;
        check("rstp_held",     button_held,     0);
        check("rstp_released", button_released, 0);
        @(negedge clock);
        button_n   = 1'b1;
        reset_s2_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("rstp_no_release", button_released, 0);
            check("rstp_no_press",   button_pressed,  0);
        end

        // Segment table
        foreach (tbl[s]) begin
            button_n = tbl[s].bn;
            np = 0;
            nr = 0;
            nl = 0;
            for (int c = 0; c < tbl[s].cycles; c++) begin
                @(negedge clock);
                np += int'(button_pressed);
                nr += int'(button_released);
                nl += int'(long_press);
            end
            check($sformatf("tbl%0d_pressed", s),  np, tbl[s].np);
            check($sformatf("tbl%0d_released", s), nr, tbl[s].nr);
            check($sformatf("tbl%0d_held", s),     button_held, tbl[s].held);
            check($sformatf("tbl%0d_long", s),     nl, (s == 8) ? 0 : tbl[s].nl);
        end
        button_n = 1'b0;
        nl = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            nl += int'(long_press);
        end
        check("tbl_long_after_bounce", nl, int'(LP));
        button_n = 1'b1;
        nr = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            nr += int'(button_released);
        end
        check("tbl_final_release", nr, 1);

        // Random runs of bouncing and stable levels, rare async resets
        run_left = 0;
        lvl      = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lvl      = ~lvl;
                run_left = ($urandom_range(0, 3) == 0)
                         ? int'($urandom_range(1, 30))
                         : int'($urandom_range(1, 8));
            end
            button_n = lvl;
            run_left--;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_s2_n = 1'b0;
                #2 reset_s2_n = 1'b1;
            end
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
